// File: rtl/vpg_pixel_fetch.sv
// -----------------------------------------------------------------------------
// vpg_pixel_fetch
// Converts (pixel_x, pixel_y) requests from the video timing generator into
// framebuffer reads, maps the returned palette index through a 256x24 palette
// and presents a registered {R,G,B} color two cycles after each request.
// A new framebuffer base can be queued at any time; it takes effect at the
// next frame start (request at 0,0) so a frame is never torn.
//
// Ports
//   clk, reset_n            pixel clock, async active-low reset
//   pixel_x/pixel_y/pix_req pixel request from the timing generator
//   fb_base/fb_base_wr      queue a new framebuffer base word address
//   mem_addr/mem_rd         framebuffer read (combinational, same cycle)
//   mem_rdata               palette index, returned one cycle after mem_rd
//   pal_wr/pal_addr/pal_data palette write port
//   border_color            color shown for blank / out-of-range pixels
//   color/color_valid       pixel color, valid when it came from the framebuffer
//   swap_pending            a queued base is waiting for the next frame start
//   ovf_err                 sticky: an out-of-range request was seen while running
//   frame_cnt               number of frame starts processed (wraps)
//
// state   | meaning
// --------+------------------------------------------------------------------
// S_ALIGN | after reset; no fetches until the first frame start is seen
// S_RUN   | locked to the frame; every in-range request is fetched
// -----------------------------------------------------------------------------
module vpg_pixel_fetch #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [9:0]  pixel_x,
    input  logic [8:0]  pixel_y,
    input  logic        pix_req,
    input  logic [18:0] fb_base,
    input  logic        fb_base_wr,
    output logic [18:0] mem_addr,
    output logic        mem_rd,
    input  logic [7:0]  mem_rdata,
    input  logic        pal_wr,
    input  logic [7:0]  pal_addr,
    input  logic [23:0] pal_data,
    input  logic [23:0] border_color,
    output logic [23:0] color,
    output logic        color_valid,
    output logic        swap_pending,
    output logic        ovf_err,
    output logic [15:0] frame_cnt
);

    typedef enum logic {
        S_ALIGN = 1'b0,
        S_RUN   = 1'b1
    } state_t;

    state_t      state;
    logic [18:0] base_act;
    logic [18:0] base_pend;
    logic        fetch_v;
    logic [23:0] palette [256];

    logic        frame_start;
    logic        in_range;
    logic [18:0] base_eff;
    logic [18:0] row_off;

    assign frame_start = pix_req && (pixel_x == 10'd0) && (pixel_y == 9'd0);
    assign in_range    = (pixel_x < 10'(H_ACTIVE)) && (pixel_y < 9'(V_ACTIVE));

    // The frame-start pixel already belongs to the new frame, so it sees the
    // queued base before the swap register updates.
    assign base_eff = (frame_start && swap_pending) ? base_pend : base_act;

    generate
        if (H_ACTIVE == 640) begin : g_row_shift
            // y*640 = y*512 + y*128
            assign row_off = ({10'd0, pixel_y} << 9) + ({10'd0, pixel_y} << 7);
        end else begin : g_row_mult
            assign row_off = 19'({10'd0, pixel_y} * 19'(H_ACTIVE));
        end
    endgenerate

    assign mem_addr = base_eff + row_off + {9'd0, pixel_x};
    assign mem_rd   = pix_req && in_range && ((state == S_RUN) || frame_start);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= S_ALIGN;
            fetch_v      <= 1'b0;
            color        <= 24'd0;
            color_valid  <= 1'b0;
            swap_pending <= 1'b0;
            ovf_err      <= 1'b0;
            frame_cnt    <= 16'd0;
            base_act     <= 19'd0;
            base_pend    <= 19'd0;
        end else begin
            fetch_v     <= mem_rd;
            color_valid <= fetch_v;
            color       <= fetch_v ? palette[mem_rdata] : border_color;

            if (pix_req && !in_range && (state == S_RUN))
                ovf_err <= 1'b1;

            if (frame_start) begin
                state     <= S_RUN;
                frame_cnt <= frame_cnt + 16'd1;
                if (swap_pending) begin
                    base_act     <= base_pend;
                    swap_pending <= 1'b0;
                end
            end

            // Placed after the swap so a coincident write stays queued for
            // the following frame.
            if (fb_base_wr) begin
                base_pend    <= fb_base;
                swap_pending <= 1'b1;
            end
        end
    end

    // Lookup above reads the pre-edge contents, so a same-cycle write to the
    // looked-up entry shows up one pixel later.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 256; i++)
                palette[i] <= {3{i[7:0]}};
        end else if (pal_wr) begin
            palette[pal_addr] <= pal_data;
        end
    end

endmodule

// File: tb/tb_vpg_pixel_fetch.sv
module tb_vpg_pixel_fetch;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [9:0]  pixel_x = '0;
    logic [8:0]  pixel_y = '0;
    logic        pix_req = 1'b0;
    logic [18:0] fb_base = '0;
    logic        fb_base_wr = 1'b0;
    logic [18:0] mem_addr;
    logic        mem_rd;
    logic [7:0]  mem_rdata = '0;
    logic        pal_wr = 1'b0;
    logic [7:0]  pal_addr = '0;
    logic [23:0] pal_data = '0;
    logic [23:0] border_color = '0;
    logic [23:0] color;
    logic        color_valid;
    logic        swap_pending;
    logic        ovf_err;
    logic [15:0] frame_cnt;

    vpg_pixel_fetch #(.H_ACTIVE(640), .V_ACTIVE(480)) dut (
        .clk(clk), .reset_n(reset_n),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .pix_req(pix_req),
        .fb_base(fb_base), .fb_base_wr(fb_base_wr),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata),
        .pal_wr(pal_wr), .pal_addr(pal_addr), .pal_data(pal_data),
        .border_color(border_color),
        .color(color), .color_valid(color_valid),
        .swap_pending(swap_pending), .ovf_err(ovf_err), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // staged stimulus, applied at the next falling edge
    bit          st_wr = 0;
    logic [18:0] st_base = '0;
    bit          st_pw = 0;
    logic [7:0]  st_pa = '0;
    logic [23:0] st_pd = '0;
    logic [23:0] st_border = 24'h0055AA;

    // reference model
    bit          m_run;
    logic [18:0] m_act, m_pend;
    bit          m_swap, m_ovf;
    logic [15:0] m_fcnt;
    logic [23:0] m_color;
    bit          m_cv;
    bit          m_s1;
    logic [18:0] m_s1_addr;
    logic [23:0] m_pal [256];
    bit          m_fs, m_inr, exp_rd;
    logic [18:0] exp_addr;

    function automatic logic [7:0] mem_byte(input logic [18:0] a);
        return a[7:0] ^ a[15:8] ^ {5'd0, a[18:16]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_act = '0; m_pend = '0; m_swap = 0; m_ovf = 0;
        m_fcnt = '0; m_color = '0; m_cv = 0; m_s1 = 0; m_s1_addr = '0;
        for (int i = 0; i < 256; i++) m_pal[i] = {3{8'(i)}};
    endtask

    task automatic model_expect();
        int base_i;
        m_fs   = pix_req && pixel_x == 0 && pixel_y == 0;
        m_inr  = (int'(pixel_x) < 640) && (int'(pixel_y) < 480);
        base_i = (m_fs && m_swap) ? int'(m_pend) : int'(m_act);
        exp_rd = pix_req && m_inr && (m_run || m_fs);
        exp_addr = 19'((base_i + int'(pixel_y) * 640 + int'(pixel_x)) % 524288);
    endtask

    task automatic model_edge();
        m_color   = m_s1 ? m_pal[mem_rdata] : border_color;
        m_cv      = m_s1;
        m_s1      = exp_rd;
        m_s1_addr = exp_addr;
        if (pal_wr) m_pal[pal_addr] = pal_data;
        if (pix_req && !m_inr && m_run) m_ovf = 1;
        if (m_fs) begin
            m_run  = 1;
            m_fcnt = m_fcnt + 16'd1;
            if (m_swap) begin
                m_act  = m_pend;
                m_swap = 0;
            end
        end
        if (fb_base_wr) begin
            m_pend = fb_base;
            m_swap = 1;
        end
    endtask

    task automatic apply(input bit req, input int x, input int y);
        pix_req      = req;
        pixel_x      = 10'(x);
        pixel_y      = 9'(y);
        fb_base_wr   = st_wr;
        fb_base      = st_base;
        pal_wr       = st_pw;
        pal_addr     = st_pa;
        pal_data     = st_pd;
        border_color = st_border;
        mem_rdata    = m_s1 ? mem_byte(m_s1_addr) : 8'($urandom);
        st_wr = 0;
        st_pw = 0;
    endtask

    task automatic step(input bit req, input int x, input int y);
        @(negedge clk);
        apply(req, x, y);
        #1;
        model_expect();
        chk("mem_rd", 32'(mem_rd), 32'(exp_rd));
        if (exp_rd) chk("mem_addr", 32'(mem_addr), 32'(exp_addr));
        chk("color", 32'(color), 32'(m_color));
        chk("color_valid", 32'(color_valid), 32'(m_cv));
        chk("swap_pending", 32'(swap_pending), 32'(m_swap));
        chk("ovf_err", 32'(ovf_err), 32'(m_ovf));
        chk("frame_cnt", 32'(frame_cnt), 32'(m_fcnt));
        model_edge();
    endtask

    task automatic do_reset();
        @(negedge clk);
        st_wr = 0; st_pw = 0;
        apply(0, 0, 0);
        reset_n = 1'b0;
        #1;
        chk("rst_color", 32'(color), 32'h0);
        chk("rst_valid", 32'(color_valid), 32'h0);
        chk("rst_swap", 32'(swap_pending), 32'h0);
        chk("rst_ovf", 32'(ovf_err), 32'h0);
        chk("rst_fcnt", 32'(frame_cnt), 32'h0);
        chk("rst_rd", 32'(mem_rd), 32'h0);
        model_reset();
        reset_n = 1'b1;
        model_expect();
        model_edge();
    endtask

    initial begin
        int vcount;
        int r, x, y;
        model_reset();
        do_reset();

        // alignment, then first frame start
        step(1, 5, 3);
        chk("align_no_rd", 32'(mem_rd), 32'h0);
        step(1, 0, 0);
        chk("fs_addr", 32'(mem_addr), 32'h0);
        chk("fs_rd", 32'(mem_rd), 32'h1);
        step(0, 0, 0);
        chk("align_border", 32'(color), 32'(st_border));
        step(0, 0, 0);
        chk("fs_color", 32'(color), 32'h000000);
        chk("fs_valid", 32'(color_valid), 32'h1);
        chk("fcnt_one", 32'(frame_cnt), 32'h1);

        // last pixel of a frame with base 0x100
        st_wr = 1; st_base = 19'h100;
        step(0, 0, 0);
        step(1, 0, 0);
        step(1, 639, 479);
        chk("last_addr", 32'(mem_addr), 32'h4B0FF);
        chk("last_rd", 32'(mem_rd), 32'h1);

        // out of range
        step(1, 640, 0);
        chk("oor_rd", 32'(mem_rd), 32'h0);
        step(1, 10, 10);
        step(1, 11, 10);
        chk("oor_border", 32'(color), 32'(st_border));
        chk("oor_invalid", 32'(color_valid), 32'h0);
        step(1, 12, 10);
        step(0, 0, 0);
        chk("ovf_sticky", 32'(ovf_err), 32'h1);

        // double base write, then swap at frame start
        st_wr = 1; st_base = 19'h2000;
        step(1, 20, 20);
        st_wr = 1; st_base = 19'h3000;
        step(1, 21, 20);
        step(0, 0, 0);
        chk("swap_pend_set", 32'(swap_pending), 32'h1);
        step(1, 0, 0);
        chk("swap_addr", 32'(mem_addr), 32'h3000);
        step(0, 0, 0);
        chk("swap_cleared", 32'(swap_pending), 32'h0);

        // base write coinciding with a frame start
        st_wr = 1; st_base = 19'h5000;
        step(1, 0, 0);
        chk("coinc_old_base", 32'(mem_addr), 32'h3000);
        step(0, 0, 0);
        chk("coinc_pending", 32'(swap_pending), 32'h1);
        st_wr = 1; st_base = 19'h6000;
        step(1, 0, 0);
        chk("coinc_prev_pend", 32'(mem_addr), 32'h5000);
        step(1, 0, 0);
        chk("coinc_next", 32'(mem_addr), 32'h6000);

        // palette write colliding with lookup
        st_wr = 1; st_base = 19'h0;
        step(0, 0, 0);
        step(1, 0, 0);
        step(1, 18, 0);
        st_pw = 1; st_pa = 8'h12; st_pd = 24'hABCDEF;
        step(0, 0, 0);
        step(0, 0, 0);
        chk("pal_old", 32'(color), 32'h121212);
        step(1, 18, 0);
        step(0, 0, 0);
        step(0, 0, 0);
        chk("pal_new", 32'(color), 32'hABCDEF);

        // a full line back-to-back
        vcount = 0;
        for (int i = 0; i < 642; i++) begin
            if (i < 640) step(1, i, 7);
            else step(0, 0, 0);
            if (color_valid) vcount++;
        end
        @(negedge clk);
        #1;
        if (color_valid) vcount++;
        chk("line_valid_count", 32'(vcount), 32'd640);

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            r = int'($urandom % 16);
            x = int'($urandom_range(0, 639));
            y = int'($urandom_range(0, 479));
            if (r == 0) begin x = 0; y = 0; end
            else if (r == 1) x = int'($urandom_range(640, 1023));
            else if (r == 2) y = int'($urandom_range(480, 511));
            st_wr   = ($urandom % 10) == 0;
            st_base = 19'($urandom);
            st_pw   = ($urandom % 4) == 0;
            st_pa   = (($urandom % 2) == 0 && m_s1) ? mem_byte(m_s1_addr) : 8'($urandom);
            st_pd   = 24'($urandom);
            if (($urandom % 16) == 0) st_border = 24'($urandom);
            step(($urandom % 4) != 0, x, y);
        end

        // reset with pixels in flight
        step(0, 0, 0);
        step(1, 0, 0);
        step(1, 2, 1);
        step(1, 3, 1);
        do_reset();
        step(0, 0, 0);
        chk("post_rst_invalid", 32'(color_valid), 32'h0);
        step(1, 4, 4);
        chk("post_rst_align", 32'(mem_rd), 32'h0);
        step(0, 0, 0);
        step(1, 0, 0);
        step(1, 1, 0);
        step(0, 0, 0);
        chk("post_rst_valid", 32'(color_valid), 32'h1);
        step(0, 0, 0);
        step(0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/vpg_pixel_fetch.md
VPG_PIXEL_FETCH -- requirements
Module: vpg_pixel_fetch

Interface
REQ-001 The block SHALL have a single clock, clk; reset is asynchronous, active-low, named reset_n.
REQ-002 Parameter H_ACTIVE, 640, active pixels per line.
REQ-003 Parameter V_ACTIVE, 480, active lines per frame.
REQ-004 clk  input  1  pixel clock, shared with the timing generator.
REQ-005 reset_n  input  1  asynchronous active-low reset.
REQ-006 pixel_x  input  10  requested pixel column.
REQ-007 pixel_y  input  9  requested pixel row.
REQ-008 pix_req  input  1  pixel request, qualifies pixel_x/pixel_y this cycle.
REQ-009 fb_base  input  19  new framebuffer base word address.
REQ-010 fb_base_wr  input  1  strobe that latches fb_base as the pending base.
REQ-011 mem_addr  output  19  framebuffer read address, combinational.
REQ-012 mem_rd  output  1  framebuffer read strobe, combinational.
REQ-013 mem_rdata  input  8  palette index, valid exactly one cycle after mem_rd.
REQ-014 pal_wr  input  1  palette write strobe.
REQ-015 pal_addr  input  8  palette write entry.
REQ-016 pal_data  input  24  palette write value {R,G,B}.
REQ-017 border_color  input  24  color driven for blank or invalid requests.
REQ-018 color  output  24  pixel color {R,G,B} for the timing generator color input.
REQ-019 color_valid  output  1  color holds fetched framebuffer data.
REQ-020 swap_pending  output  1  a latched base is waiting for frame start.
REQ-021 ovf_err  output  1  sticky out-of-range request flag.
REQ-022 frame_cnt  output  16  count of frame starts seen.

Function
REQ-023 FSM states: S_ALIGN and S_RUN.
REQ-024 In S_ALIGN the block SHALL hold mem_rd=0, and color=border_color with color_valid=0 two cycles after each request.
REQ-025 Frame start: pix_req=1 with pixel_x=0 and pixel_y=0.
REQ-026 A frame start in S_ALIGN SHALL move the FSM to S_RUN, and that pixel SHALL be fetched normally.
REQ-027 In S_RUN the FSM SHALL remain in S_RUN until reset.
REQ-028 In-range request in S_RUN (pixel_x<H_ACTIVE, pixel_y<V_ACTIVE): mem_rd=1 in the same cycle.
REQ-029 For that request, mem_addr = base_act + pixel_y*H_ACTIVE + pixel_x, computed with shift-add and truncated modulo 2^19.
REQ-030 Latency: a request in cycle t SHALL produce color in cycle t+2, registered, with no bubbles at one request per cycle.
REQ-031 In cycle t+1, mem_rdata SHALL index the palette and the entry SHALL be registered into color; color_valid=1 in cycle t+2.
REQ-032 Out-of-range request in S_RUN: mem_rd=0; at t+2 color=border_color and color_valid=0; ovf_err set to 1.
REQ-033 ovf_err SHALL clear only on reset.
REQ-034 pix_req=0: mem_rd=0; at t+2 color=border_color and color_valid=0.
REQ-035 fb_base_wr SHALL latch fb_base into base_pend and set swap_pending=1.
REQ-036 A second fb_base_wr before a swap SHALL overwrite base_pend.
REQ-037 On a frame start with swap_pending=1: base_act<=base_pend, swap_pending<=0.
REQ-038 The frame-start pixel itself SHALL use the new base.
REQ-039 If fb_base_wr coincides with a frame start, the frame SHALL use the previously pending value if one exists, otherwise the old base_act.
REQ-040 A fb_base_wr coinciding with a frame start SHALL leave swap_pending=1 for the next frame.
REQ-041 frame_cnt SHALL increment by 1 on every frame start that is processed in S_RUN or causes the S_ALIGN->S_RUN transition, wrapping 0xFFFF->0.
REQ-042 The palette SHALL be 256x24 registers, written on pal_wr at clk edge.
REQ-043 A palette lookup and a write to the same entry in the same cycle SHALL return the old value; the new value is visible from the next cycle.

Reset
REQ-044 On reset assertion: state=S_ALIGN, color=0, color_valid=0, swap_pending=0, ovf_err=0, frame_cnt=0, base_act=0, base_pend=0.
REQ-045 On reset assertion, palette entry i SHALL be {i,i,i}.
REQ-046 Reset mid-operation SHALL discard in-flight pixels; no color_valid after release until a new in-range S_RUN request, 2 cycles later.

Verification
REQ-047 Reset, then requests (5,3) and (0,0) -> (5,3) yields mem_rd=0 and border color; (0,0) yields mem_addr=0, color at t+2 = {idx,idx,idx}, frame_cnt=1.
REQ-048 Run, base=0x100, request (639,479) -> mem_addr=0x100+307199=0x4B0FF, mem_rd=1.
REQ-049 Request (640,0) -> mem_rd=0, color=border_color at t+2, ovf_err=1 and stays 1 after later valid pixels.
REQ-050 fb_base_wr=0x2000 mid-frame then again 0x3000 -> swap_pending=1; next (0,0) uses mem_addr=0x3000; swap_pending=0.
REQ-051 Write pal[0x12]=0xABCDEF in the same cycle mem_rdata=0x12 is looked up -> that pixel shows the old value 0x121212; the next pixel with 0x12 shows 0xABCDEF.
REQ-052 Back-to-back 640 in-range requests -> 640 consecutive color_valid cycles, each exactly 2 cycles after its request.
